// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
//   Multi-cycle adder/subtractor. WIDTH-bit operands are processed LSB-first,
//   SLICE bits per clock, by a ripple chain of SLICE full-adder cells. The
//   partial sum accumulates internally. The visible result registers change
//   only when the last slice completes.
//
//   Parameters
//     WIDTH  operand/result width in bits (>= 2)
//     SLICE  bits per RUN cycle; must divide WIDTH (WIDTH = single-cycle)
//
//   Ports
//     clk_i       clock, rising edge
//     rst_ni      asynchronous active-low reset
//     start_i     request, sampled only in IDLE or DONE
//     sub_i       0: a_i + b_i, 1: a_i - b_i (sampled with start_i)
//     a_i, b_i    operands (sampled with start_i)
//     busy_o      high while the operation is running
//     done_o      one-cycle pulse, results valid
//     sum_o       result mod 2^WIDTH
//     carry_o     add: carry out; sub: 1 = no borrow, 0 = borrow
//     overflow_o  two's complement overflow
// ---------------------------------------------------------------------------
module serial_add_sub #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             overflow_o
);

   localparam int N     = WIDTH / SLICE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   // Slice adder signals
   logic [SLICE-1:0]   a_sl;
   logic [SLICE-1:0]   b_sl;
   logic [SLICE-1:0]   s_sl;
   logic               rip_c;
   logic               c_msb_in;
   logic               c_out_sl;
   logic               last_slice;
   logic [WIDTH-1:0]   acc_next;

   // Operands are shifted right each RUN cycle, so the active slice is
   // always the low SLICE bits; no variable indexing is needed.
   assign a_sl       = a_q[SLICE-1:0];
   assign b_sl       = b_q[SLICE-1:0];
   assign last_slice = (cnt_q == CNT_W'(N - 1));

   // Ripple chain of SLICE full-adder cells. c_msb_in keeps the carry into
   // the top cell; on the last slice that is the carry into the result MSB,
   // which gives the overflow flag.
   always_comb begin
      s_sl     = '0;
      rip_c    = carry_q;
      c_msb_in = carry_q;
      for (int i = 0; i < SLICE; i++) begin
         c_msb_in = rip_c;
         s_sl[i]  = a_sl[i] ^ b_sl[i] ^ rip_c;
         rip_c    = (a_sl[i] & b_sl[i]) | (rip_c & (a_sl[i] ^ b_sl[i]));
      end
      c_out_sl = rip_c;
   end

   // The new slice enters at the top of the accumulator while older slices
   // shift down. After N cycles slice 0 sits at bit 0.
   assign acc_next = (acc_q >> SLICE) | (WIDTH'(s_sl) << (WIDTH - SLICE));

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               // Subtraction is a + ~b + 1: invert b here and seed the carry.
               a_d     = a_i;
               b_d     = b_i ^ {WIDTH{sub_i}};
               carry_d = sub_i;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            a_d     = a_q >> SLICE;
            b_d     = b_q >> SLICE;
            acc_d   = acc_next;
            carry_d = c_out_sl;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_slice) begin
               sum_d   = acc_next;
               cout_d  = c_out_sl;
               ovf_d   = c_msb_in ^ c_out_sl;
               cnt_d   = '0;
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy_o     = (state_q == RUN);
   assign done_o     = (state_q == DONE);
   assign sum_o      = sum_q;
   assign carry_o    = cout_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sub
//   Directed bench for serial_add_sub. Four instances cover the configurations
//   of interest:
//     index 0: WIDTH=8 SLICE=1
//     index 1: WIDTH=8 SLICE=2
//     index 2: WIDTH=4 SLICE=1
//     index 3: WIDTH=8 SLICE=8
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_add_sub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [3:0]       st;
   logic [3:0]       sb;
   logic [3:0][7:0]  av;
   logic [3:0][7:0]  bv;
   wire  [3:0]       bz;
   wire  [3:0]       dn;
   wire  [3:0]       cy;
   wire  [3:0]       ov;
   wire  [3:0][7:0]  sm;
   wire  [3:0]       sm4;

   assign sm[2] = {4'h0, sm4};

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] last_sum [4];

   serial_add_sub #(.WIDTH(8), .SLICE(1)) u_s1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st[0]), .sub_i(sb[0]),
      .a_i(av[0]), .b_i(bv[0]), .busy_o(bz[0]), .done_o(dn[0]),
      .sum_o(sm[0]), .carry_o(cy[0]), .overflow_o(ov[0]));

   serial_add_sub #(.WIDTH(8), .SLICE(2)) u_s2 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st[1]), .sub_i(sb[1]),
      .a_i(av[1]), .b_i(bv[1]), .busy_o(bz[1]), .done_o(dn[1]),
      .sum_o(sm[1]), .carry_o(cy[1]), .overflow_o(ov[1]));

   serial_add_sub #(.WIDTH(4), .SLICE(1)) u_w4 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st[2]), .sub_i(sb[2]),
      .a_i(av[2][3:0]), .b_i(bv[2][3:0]), .busy_o(bz[2]), .done_o(dn[2]),
      .sum_o(sm4), .carry_o(cy[2]), .overflow_o(ov[2]));

   serial_add_sub #(.WIDTH(8), .SLICE(8)) u_s8 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(st[3]), .sub_i(sb[3]),
      .a_i(av[3]), .b_i(bv[3]), .busy_o(bz[3]), .done_o(dn[3]),
      .sum_o(sm[3]), .carry_o(cy[3]), .overflow_o(ov[3]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // 4-bit reference: carry/sum from the full-width add, overflow from the
   // operand/result sign rule. Returns {ovf, carry, sum[3:0]}.
   function automatic logic [5:0] ref4(input logic sub, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] t;
      logic       o;
      t = {1'b0, a} + {1'b0, b ^ {4{sub}}} + {4'b0, sub};
      if (!sub) o = (a[3] == b[3]) && (t[3] != a[3]);
      else      o = (a[3] != b[3]) && (t[3] != a[3]);
      return {o, t[4], t[3:0]};
   endfunction

   // One operation on instance d with n slices. If disturb > 0, start_i is
   // pulsed with different operands on that RUN cycle.
   task automatic run_op(input int d, input int n, input logic sub,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input int disturb);
      int j;
      int busy_cnt;
      bit got;
      @(negedge clk);
      st[d] = 1'b1; sb[d] = sub; av[d] = a; bv[d] = b;
      @(posedge clk);
      j = 0; busy_cnt = 0; got = 1'b0;
      while (!got && j < 40) begin
         @(negedge clk);
         j++;
         if (bz[d]) busy_cnt++;
         if (j == n) check("hold_prev", {24'b0, sm[d]}, {24'b0, last_sum[d]});
         if (dn[d]) got = 1'b1;
         if (j == 1) st[d] = 1'b0;
         if (j == disturb) begin
            st[d] = 1'b1; sb[d] = ~sub; av[d] = ~a; bv[d] = 8'h5A;
         end
         if (j == disturb + 1) st[d] = 1'b0;
      end
      check("done_seen", {31'b0, got}, 32'd1);
      check("latency", j - 1, n);
      check("busy_cycles", busy_cnt, n);
      check("done_busy_excl", {31'b0, bz[d]}, 32'd0);
      check("sum", {24'b0, sm[d]}, {24'b0, es});
      check("carry", {31'b0, cy[d]}, {31'b0, ec});
      check("overflow", {31'b0, ov[d]}, {31'b0, eo});
      last_sum[d] = es;
      @(negedge clk);
      check("done_one_cycle", {31'b0, dn[d]}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] r;
      bit         any_done;

      rst_n = 1'b0;
      st = '0; sb = '0; av = '0; bv = '0;
      for (int i = 0; i < 4; i++) last_sum[i] = 8'h00;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("rst_busy", {31'b0, bz[i]}, 32'd0);
         check("rst_done", {31'b0, dn[i]}, 32'd0);
         check("rst_sum", {24'b0, sm[i]}, 32'd0);
         check("rst_carry", {31'b0, cy[i]}, 32'd0);
         check("rst_ovf", {31'b0, ov[i]}, 32'd0);
      end
      rst_n = 1'b1;

      // Bit-serial, WIDTH=8
      run_op(0, 8, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
      run_op(0, 8, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);

      // Two bits per cycle, subtraction
      run_op(1, 4, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 0);
      run_op(1, 4, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0);

      // Exhaustive 4-bit sweep
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               r = ref4(s[0], a[3:0], b[3:0]);
               run_op(2, 4, s[0], {4'h0, a[3:0]}, {4'h0, b[3:0]},
                      {4'h0, r[3:0]}, r[4], r[5], 0);
            end
         end
      end

      // start_i pulsed during RUN with other operands is ignored
      run_op(0, 8, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 3);
      run_op(0, 8, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0);

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      st[0] = 1'b1; sb[0] = 1'b0; av[0] = 8'h7F; bv[0] = 8'h01;
      @(posedge clk);
      @(negedge clk);
      st[0] = 1'b0;
      check("abort_busy_before", {31'b0, bz[0]}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {31'b0, bz[0]}, 32'd0);
      check("abort_done", {31'b0, dn[0]}, 32'd0);
      check("abort_sum", {24'b0, sm[0]}, 32'd0);
      check("abort_carry", {31'b0, cy[0]}, 32'd0);
      check("abort_ovf", {31'b0, ov[0]}, 32'd0);
      check("abort_sum_other", {24'b0, sm[1]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) last_sum[i] = 8'h00;
      any_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (dn[0] || bz[0]) any_done = 1'b1;
      end
      check("abort_no_done", {31'b0, any_done}, 32'd0);
      run_op(0, 8, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 0);

      // Single-cycle slice, start held high: back-to-back operations
      @(negedge clk);
      st[3] = 1'b1; sb[3] = 1'b0; av[3] = 8'hFF; bv[3] = 8'h01;
      @(posedge clk);
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk);
         check("b2b_done", {31'b0, dn[3]}, (j == 2 || j == 4 || j == 6) ? 32'd1 : 32'd0);
         check("b2b_busy", {31'b0, bz[3]}, (j == 1 || j == 3 || j == 5) ? 32'd1 : 32'd0);
         if (j == 1) begin
            sb[3] = 1'b1; av[3] = 8'h10; bv[3] = 8'h10;
         end
         if (j == 2) begin
            check("b2b_sum0", {24'b0, sm[3]}, 32'h00);
            check("b2b_carry0", {31'b0, cy[3]}, 32'd1);
            check("b2b_ovf0", {31'b0, ov[3]}, 32'd0);
         end
         if (j == 3) begin
            sb[3] = 1'b0; av[3] = 8'h7F; bv[3] = 8'h01;
         end
         if (j == 4) begin
            check("b2b_sum1", {24'b0, sm[3]}, 32'h00);
            check("b2b_carry1", {31'b0, cy[3]}, 32'd1);
            check("b2b_ovf1", {31'b0, ov[3]}, 32'd0);
         end
         if (j == 5) st[3] = 1'b0;
         if (j == 6) begin
            check("b2b_sum2", {24'b0, sm[3]}, 32'h80);
            check("b2b_carry2", {31'b0, cy[3]}, 32'd0);
            check("b2b_ovf2", {31'b0, ov[3]}, 32'd1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
